board_game_core: RTL and testbench

Parametrised N×N board engine for the tic-tac-toe family of games, generalised to K-in-a-row.
- Holds the board state, a cursor moved by the 4-way direction input, and alternating turns.
- On each accepted placement, runs a sequential scan through the placed cell and reports the winner.
- Sits between the input decoder (direction and place buttons) and the display and winner logic.

---
 rtl/board_pkg.sv | 20 ++
 rtl/line_scanner.sv | 75 +++++++
 rtl/board_game_core.sv | 130 +++++++++++++
 tb/tb_board_game_core.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared codes and FSM state type for the K-in-a-row board engine.
package board_pkg;

    localparam logic [1:0] CELL_O     = 2'b00;
    localparam logic [1:0] CELL_X     = 2'b01;
    localparam logic [1:0] CELL_EMPTY = 2'b10;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_O    = 2'b01;
    localparam logic [1:0] WIN_X    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_RIGHT = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    typedef enum logic [2:0] {IDLE, WRITE, SCAN, RESOLVE, OVER} state_t;

endpackage

// File: rtl/line_scanner.sv
// Walks outward from the placed cell, one neighbour per cycle, over four axes
// in both senses; flags done/win combinationally for the current neighbour.
module line_scanner #(
    parameter int N  = 3,
    parameter int K  = 3,
    parameter int CW = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 en,
    input  logic [CW-1:0]        orow,
    input  logic [CW-1:0]        ocol,
    input  logic [1:0]           player,
    input  logic [N*N-1:0][1:0]  cells,
    output logic                 done,
    output logic                 win
);
    localparam int CNTW = $clog2(K+1);
    localparam int IW   = $clog2(N*N);

    logic [1:0]        axis;
    logic              neg;
    logic [CW-1:0]     step;
    logic [CNTW-1:0]   count;
    logic signed [CW:0] dl, ro, co, nr, nc;
    logic [IW-1:0]     idx;
    logic              on_board, hit, last;

    // Step only grows after an on-board match, so a coordinate never exceeds N;
    // when N is a power of two, N wraps negative and still reads as off-board.
    always_comb begin
        dl = neg ? -$signed({1'b0, step}) : $signed({1'b0, step});
        ro = $signed({1'b0, orow});
        co = $signed({1'b0, ocol});
        nr = ro;
        nc = co;
        case (axis)
            2'd0:    nc = co + dl;
            2'd1:    nr = ro + dl;
            2'd2:    begin nr = ro + dl; nc = co + dl; end
            default: begin nr = ro + dl; nc = co - dl; end
        endcase
        on_board = (nr >= 0) && (nr < N) && (nc >= 0) && (nc < N);
        idx      = IW'(nr[CW-1:0]) * IW'(N) + IW'(nc[CW-1:0]);
        hit      = on_board && (cells[idx] == player);
        last     = (count == CNTW'(K-1));
        win      = en && hit && last;
        done     = en && ((hit && last) || (!hit && neg && axis == 2'd3));
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            axis  <= 2'd0;
            neg   <= 1'b0;
            step  <= CW'(1);
            count <= CNTW'(1);
        end else if (en) begin
            if (hit) begin
                count <= count + CNTW'(1);
                step  <= step + CW'(1);
            end else begin
                step <= CW'(1);
                if (!neg) begin
                    neg <= 1'b1;
                end else begin
                    neg   <= 1'b0;
                    axis  <= axis + 2'd1;
                    count <= CNTW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/board_game_core.sv
// N x N K-in-a-row engine: board, cursor, turns and win/draw resolution.
// Define BOARD_CURSOR_WRAP_EN to make the cursor wrap at board edges.
module board_game_core
    import board_pkg::*;
#(
    parameter  int N  = 3,
    parameter  int K  = 3,
    localparam int CW = $clog2(N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              new_game,
    input  logic [1:0]        dir,
    input  logic              move_valid,
    input  logic              place_valid,
    output logic [CW-1:0]     cursor_row,
    output logic [CW-1:0]     cursor_col,
    output logic [2*N*N-1:0]  board,
    output logic              turn,
    output logic              busy,
    output logic              place_reject,
    output logic [1:0]        winner
);
    localparam int FW = $clog2(N*N+1);
    localparam int IW = $clog2(N*N);
`ifdef BOARD_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    state_t               state;
    logic [N*N-1:0][1:0]  cells;
    logic [FW-1:0]        filled;
    logic                 win_q, clear, cur_empty, scan_done, scan_win;
    logic [IW-1:0]        cur_idx;
    logic [1:0]           stone;

    assign clear     = reset | new_game;
    assign cur_idx   = IW'(cursor_row) * IW'(N) + IW'(cursor_col);
    assign cur_empty = (cells[cur_idx] == CELL_EMPTY);
    assign stone     = turn ? CELL_X : CELL_O;
    assign board     = cells;

    function automatic logic [CW-1:0] nudge(input logic [CW-1:0] c, input logic inc);
        if (inc) begin
            if (c == CW'(N-1)) return WRAP ? '0 : c;
            return c + CW'(1);
        end
        if (c == '0) return WRAP ? CW'(N-1) : c;
        return c - CW'(1);
    endfunction

    line_scanner #(.N(N), .K(K), .CW(CW)) u_scan (
        .clk    (clk),
        .reset  (clear),
        .start  (state == WRITE),
        .en     (state == SCAN),
        .orow   (cursor_row),
        .ocol   (cursor_col),
        .player (stone),
        .cells  (cells),
        .done   (scan_done),
        .win    (scan_win)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= IDLE;
            cells        <= {N*N{CELL_EMPTY}};
            cursor_row   <= '0;
            cursor_col   <= '0;
            turn         <= 1'b0;
            busy         <= 1'b0;
            place_reject <= 1'b0;
            winner       <= WIN_NONE;
            filled       <= '0;
            win_q        <= 1'b0;
        end else begin
            place_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (place_valid) begin
                        if (cur_empty) begin
                            state <= WRITE;
                            busy  <= 1'b1;
                        end else begin
                            place_reject <= 1'b1;
                        end
                    end else if (move_valid) begin
                        case (dir)
                            DIR_UP:    cursor_row <= nudge(cursor_row, 1'b0);
                            DIR_DOWN:  cursor_row <= nudge(cursor_row, 1'b1);
                            DIR_RIGHT: cursor_col <= nudge(cursor_col, 1'b1);
                            DIR_LEFT:  cursor_col <= nudge(cursor_col, 1'b0);
                        endcase
                    end
                end
                WRITE: begin
                    cells[cur_idx] <= stone;
                    state          <= SCAN;
                end
                SCAN: begin
                    if (scan_done) begin
                        win_q <= scan_win;
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    busy <= 1'b0;
                    if (win_q) begin
                        winner <= turn ? WIN_X : WIN_O;
                        state  <= OVER;
                    end else begin
                        filled <= filled + FW'(1);
                        if (filled == FW'(N*N-1)) begin
                            winner <= WIN_DRAW;
                            state  <= OVER;
                        end else begin
                            turn  <= ~turn;
                            state <= IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_game_core.sv
// Directed bench: a 3x3/K=3 and a 5x5/K=4 instance share one stimulus stream.
module tb_board_game_core;
`ifdef BOARD_CURSOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, new_game, move_valid, place_valid;
    logic [1:0] dir;
    logic [1:0] row3, col3, win3;
    logic [17:0] board3;
    logic turn3, busy3, rej3;
    logic [2:0] row5, col5;
    logic [1:0] win5;
    logic [49:0] board5;
    logic turn5, busy5, rej5;

    int nchk = 0, nerr = 0;
    int cr, cc, lat;
    logic sel;
    logic [17:0] expb;

    always #5 clk = ~clk;

    board_game_core #(.N(3), .K(3)) dut3 (
        .clk(clk), .reset(reset), .new_game(new_game), .dir(dir),
        .move_valid(move_valid), .place_valid(place_valid),
        .cursor_row(row3), .cursor_col(col3), .board(board3), .turn(turn3),
        .busy(busy3), .place_reject(rej3), .winner(win3));

    board_game_core #(.N(5), .K(4)) dut5 (
        .clk(clk), .reset(reset), .new_game(new_game), .dir(dir),
        .move_valid(move_valid), .place_valid(place_valid),
        .cursor_row(row5), .cursor_col(col5), .board(board5), .turn(turn5),
        .busy(busy5), .place_reject(rej5), .winner(win5));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [1:0] d);
        dir = d; move_valid = 1'b1;
        tick();
        move_valid = 1'b0;
    endtask

    task automatic goto(input int r, input int c);
        while (cr < r) begin move(2'b01); cr++; end
        while (cr > r) begin move(2'b00); cr--; end
        while (cc < c) begin move(2'b10); cc++; end
        while (cc > c) begin move(2'b11); cc--; end
    endtask

    task automatic clear_all(input bit hard);
        if (hard) reset = 1'b1; else new_game = 1'b1;
        tick();
        reset = 1'b0; new_game = 1'b0;
        cr = 0; cc = 0;
        expb = {9{2'b10}};
    endtask

    task automatic pulse_place();
        place_valid = 1'b1;
        tick();
        place_valid = 1'b0;
    endtask

    // Place stone p at (r,c) and wait for busy to drop; lat counts edges from the request.
    task automatic place_at(input int r, input int c, input logic [1:0] p, output int l);
        goto(r, c);
        pulse_place();
        l = 1;
        while ((sel ? busy5 : busy3) && l < 60) begin tick(); l++; end
        if (sel ? busy5 : busy3) check("busy_timeout", 1, 0);
        if (!sel) expb[2*(r*3+c) +: 2] = p;
    endtask

    int dr[9] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
    int dc[9] = '{0, 1, 2, 1, 0, 2, 1, 0, 2};
    int fr[8] = '{4, 0, 4, 1, 2, 2, 4, 3};
    int fc[8] = '{4, 3, 2, 2, 4, 1, 0, 0};

    initial begin
        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; place_valid = 1'b0; dir = 2'b00;
        sel = 1'b0;
        tick(); tick();
        reset = 1'b0; cr = 0; cc = 0; expb = {9{2'b10}};

        check("rst_board", board3, 18'h2aaaa);
        check("rst_row", row3, 0);
        check("rst_col", col3, 0);
        check("rst_turn", turn3, 0);
        check("rst_winner", win3, 0);
        check("rst_busy", busy3, 0);
        check("rst_reject", rej3, 0);
        check("rst_board5", board5, {25{2'b10}});

        move(2'b00);
        check("wrap_row3", row3, WRAP ? 2 : 0);
        check("wrap_col3", col3, 0);
        check("wrap_row5", row5, WRAP ? 4 : 0);
        clear_all(1'b0);

        // O takes the top row, X two cells of the middle row
        place_at(0, 0, 2'b00, lat);
        place_at(1, 0, 2'b01, lat);
        place_at(0, 1, 2'b00, lat);
        place_at(1, 1, 2'b01, lat);
        check("win_pending", win3, 2'b00);
        place_at(0, 2, 2'b00, lat);
        check("win_o", win3, 2'b01);
        check("win_busy", busy3, 0);
        check("win_lat", lat <= 18, 1);
        check("win_board", board3, expb);
        check("win_turn", turn3, 0);
        goto(2, 2);
        pulse_place();
        check("over_noreject", rej3, 0);
        tick();
        check("over_board", board3, expb);
        check("over_winner", win3, 2'b01);
        check("over_busy", busy3, 0);

        clear_all(1'b0);
        place_at(0, 0, 2'b00, lat);
        place_at(1, 1, 2'b01, lat);
        goto(1, 1);
        pulse_place();
        check("rej_pulse", rej3, 1);
        tick();
        check("rej_drop", rej3, 0);
        check("rej_turn", turn3, 0);
        check("rej_board", board3, expb);

        clear_all(1'b0);
        for (int i = 0; i < 9; i++) begin
            place_at(dr[i], dc[i], (i % 2 == 1) ? 2'b01 : 2'b00, lat);
            if (i == 7) check("draw_pending", win3, 2'b00);
        end
        check("draw_winner", win3, 2'b11);
        check("draw_busy", busy3, 0);
        check("draw_board", board3, expb);
        check("draw_turn", turn3, 0);

        // 5x5, K=4: X completes the anti-diagonal (0,3)..(3,0)
        sel = 1'b1;
        clear_all(1'b0);
        for (int i = 0; i < 8; i++) begin
            place_at(fr[i], fc[i], (i % 2 == 1) ? 2'b01 : 2'b00, lat);
            if (i == 6) check("n5_pending", win5, 2'b00);
        end
        check("n5_winner", win5, 2'b10);
        check("n5_lat", lat <= 26, 1);
        check("n5_busy", busy5, 0);
        check("n5_turn", turn5, 1);
        check("n5_reject", rej5, 0);
        check("n5_cursor", {row5, col5}, {3'd3, 3'd0});

        sel = 1'b0;
        clear_all(1'b1);
        place_at(0, 0, 2'b00, lat);
        goto(1, 1);
        pulse_place();
        tick(); tick(); tick();
        check("abort_busy", busy3, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_board", board3, 18'h2aaaa);
        check("abort_row", row3, 0);
        check("abort_col", col3, 0);
        check("abort_turn", turn3, 0);
        check("abort_winner", win3, 0);
        check("abort_busy_low", busy3, 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
